// File: rtl/mips_defs.sv
// mips_defs: constants and types shared by the instruction-fetch stage.
//   RESET_PC / EXC_ENTRY : PC after reset / exception handler entry
//   IM_LO / IM_HI        : legal instruction-memory fetch window
//   EXC_NONE / EXC_ADEL  : IF/ID exception codes (none / fetch address error)
//   NOP                  : instruction word used for bubbles
package mips_defs;

  localparam logic [31:0] RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;
  localparam logic [31:0] IM_LO     = 32'h0000_3000;
  localparam logic [31:0] IM_HI     = 32'h0000_6FFC;

  localparam logic [4:0]  EXC_NONE  = 5'd0;
  localparam logic [4:0]  EXC_ADEL  = 5'd4;

  localparam logic [31:0] NOP       = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        bd;
    logic [4:0]  exccode;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{instr: NOP, pc: 32'h0, bd: 1'b0, exccode: EXC_NONE};

  // Fetch address error: misaligned or outside the instruction memory window.
  function automatic logic fetch_err(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || (addr < IM_LO) || (addr > IM_HI);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: bundles the fetch-stage control inputs, the instruction
// memory port and the IF/ID register outputs.
//   master : the fetch stage (drives imem_addr and ifid_*)
//   slave  : the surrounding pipeline / memory (drives control and imem_rdata)
interface fetch_stage_if;

  logic        stall;
  logic        id_is_jump;
  logic        br_taken;
  logic [31:0] br_target;
  logic        eret;
  logic [31:0] epc;
  logic        exc_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc8;
  logic        ifid_bd;
  logic [4:0]  ifid_exccode;

  modport master (
    input  stall, id_is_jump, br_taken, br_target, eret, epc, exc_req, imem_rdata,
    output imem_addr, ifid_instr, ifid_pc, ifid_pc8, ifid_bd, ifid_exccode
  );

  modport slave (
    output stall, id_is_jump, br_taken, br_target, eret, epc, exc_req, imem_rdata,
    input  imem_addr, ifid_instr, ifid_pc, ifid_pc8, ifid_bd, ifid_exccode
  );

endinterface

// File: rtl/npc_sel.sv
// npc_sel: combinational next-PC selection and fetch-error detection.
//   i_pc                 : current PC
//   i_exc_req            : CP0 flush (highest priority)
//   i_stall              : hazard stall, PC holds
//   i_eret / i_epc       : return from exception
//   i_br_taken / i_br_target : taken branch/jump redirect
//   o_npc                : PC to load at the next edge
//   o_ferr               : current PC is not a legal fetch address
module npc_sel
  import mips_defs::*;
(
  input  logic [31:0] i_pc,
  input  logic        i_exc_req,
  input  logic        i_stall,
  input  logic        i_eret,
  input  logic [31:0] i_epc,
  input  logic        i_br_taken,
  input  logic [31:0] i_br_target,
  output logic [31:0] o_npc,
  output logic        o_ferr
);

  logic [31:0] w_pc_plus4;

  // Wraps modulo 2^32; a wrapped address is caught by o_ferr on the next fetch.
  assign w_pc_plus4 = i_pc + 32'd4;
  assign o_ferr     = fetch_err(i_pc);

  always_comb begin
    o_npc = w_pc_plus4;
    if (i_exc_req) begin
      o_npc = EXC_ENTRY;
    end else if (i_stall) begin
      o_npc = i_pc;
    end else if (i_eret) begin
      o_npc = i_epc;
    end else if (i_br_taken) begin
      o_npc = i_br_target;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction-fetch stage. Holds the PC, drives the
// combinational instruction-memory address and the IF/ID pipeline register.
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : fetch_stage_if.master (control inputs, imem port, IF/ID outputs)
module fetch_stage
  import mips_defs::*;
(
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master bus
);

  logic [31:0] r_pc;
  ifid_t       r_ifid;
  logic [31:0] w_npc;
  logic        w_ferr;

  npc_sel u_npc_sel (
    .i_pc        (r_pc),
    .i_exc_req   (bus.exc_req),
    .i_stall     (bus.stall),
    .i_eret      (bus.eret),
    .i_epc       (bus.epc),
    .i_br_taken  (bus.br_taken),
    .i_br_target (bus.br_target),
    .o_npc       (w_npc),
    .o_ferr      (w_ferr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc   <= RESET_PC;
      r_ifid <= IFID_BUBBLE;
    end else begin
      r_pc <= w_npc;
      if (bus.exc_req) begin
        r_ifid <= IFID_BUBBLE;
      end else if (!bus.stall) begin
        // eret has no delay slot, so whatever was fetched behind it is squashed.
        if (bus.eret) begin
          r_ifid <= IFID_BUBBLE;
        end else begin
          r_ifid.instr   <= w_ferr ? NOP : bus.imem_rdata;
          r_ifid.pc      <= r_pc;
          r_ifid.bd      <= bus.id_is_jump;
          r_ifid.exccode <= w_ferr ? EXC_ADEL : EXC_NONE;
        end
      end
    end
  end

  assign bus.imem_addr    = r_pc;
  assign bus.ifid_instr   = r_ifid.instr;
  assign bus.ifid_pc      = r_ifid.pc;
  assign bus.ifid_bd      = r_ifid.bd;
  assign bus.ifid_exccode = r_ifid.exccode;
  assign bus.ifid_pc8     = r_ifid.pc + 32'd8;

endmodule
